// File: rtl/taus88_pkg.sv
// Shared Taus88 constants, state encoding and per-component helpers.
package taus88_pkg;

  localparam logic [31:0] MASK1 = 32'hFFFF_FFFE;
  localparam logic [31:0] MASK2 = 32'hFFFF_FFF8;
  localparam logic [31:0] MASK3 = 32'hFFFF_FFF0;

  localparam int S1_A = 13, S1_B = 19, S1_C = 12;
  localparam int S2_A = 2,  S2_B = 25, S2_C = 4;
  localparam int S3_A = 3,  S3_B = 11, S3_C = 17;

  localparam logic [31:0] S1_MIN = 32'd2;
  localparam logic [31:0] S2_MIN = 32'd8;
  localparam logic [31:0] S3_MIN = 32'd16;

  localparam logic [31:0] S1_INIT = 32'd1634404289;
  localparam logic [31:0] S2_INIT = 32'd8;
  localparam logic [31:0] S3_INIT = 32'd16;

  typedef enum logic [0:0] {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

  function automatic logic [31:0] taus88_step(input logic [31:0] s, input logic [31:0] mask,
                                              input int a, input int b, input int c);
    logic [31:0] t;
    t = ((s << a) ^ s) >> b;
    return ((s & mask) << c) ^ t;
  endfunction

  // Components below their minimum would lock the generator into a short cycle.
  function automatic logic [95:0] taus88_fixup(input logic [95:0] seed);
    logic [31:0] s1, s2, s3;
    s1 = seed[31:0];
    s2 = seed[63:32];
    s3 = seed[95:64];
    if (s1 < S1_MIN) s1 = s1 + S1_MIN;
    if (s2 < S2_MIN) s2 = s2 + S2_MIN;
    if (s3 < S3_MIN) s3 = s3 + S3_MIN;
    return {s3, s2, s1};
  endfunction

endpackage

// File: rtl/taus88_multi_core_lane.sv
// One Taus88 lane: three component registers, load has priority over advance.
module taus88_lane
  import taus88_pkg::*;
#(
  parameter int LANE_ID = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adv,
  input  logic        load,
  input  logic [95:0] seed,
  output logic [31:0] out
);

  logic [31:0] s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= S1_INIT + 32'(LANE_ID);
      s2 <= S2_INIT + 32'(LANE_ID);
      s3 <= S3_INIT + 32'(LANE_ID);
    end else if (load) begin
      s1 <= seed[31:0];
      s2 <= seed[63:32];
      s3 <= seed[95:64];
    end else if (adv) begin
      s1 <= taus88_step(s1, MASK1, S1_A, S1_B, S1_C);
      s2 <= taus88_step(s2, MASK2, S2_A, S2_B, S2_C);
      s3 <= taus88_step(s3, MASK3, S3_A, S3_B, S3_C);
    end
  end

  assign out = s1 ^ s2 ^ s3;

endmodule

// File: rtl/taus88_multi_core.sv
// LANES lockstep Taus88 generators behind a valid/ready stream, with per-lane re-seed and warm-up discard.
module taus88_multi_core
  import taus88_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int WARMUP = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  seed_valid,
  output logic                  seed_ready,
  input  logic [3:0]            seed_lane,
  input  logic [95:0]           seed_data,
  output logic                  seed_err,
  output logic                  rnd_valid,
  input  logic                  rnd_ready,
  output logic [32*LANES-1:0]   rnd_data
);

  localparam int          CW        = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [CW-1:0] WARM_LOAD = CW'(WARMUP);
  localparam logic [4:0]  LANES_W   = 5'(LANES);

  state_t       state;
  logic [CW-1:0] cnt;
  logic         lane_ok;
  logic         adv_all;
  logic [95:0]  seed_fixed;

  assign seed_ready = 1'b1;
  assign lane_ok    = {1'b0, seed_lane} < LANES_W;
  // Warm-up always advances; in RUN only a completed transfer advances.
  assign adv_all    = (state == ST_WARMUP) || (rnd_valid && rnd_ready);
  assign seed_fixed = taus88_fixup(seed_data);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    taus88_lane #(.LANE_ID(k)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .adv   (adv_all),
      .load  (seed_valid && lane_ok && (seed_lane == 4'(k))),
      .seed  (seed_fixed),
      .out   (rnd_data[32*k +: 32])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= (WARMUP == 0) ? ST_RUN : ST_WARMUP;
      cnt       <= WARM_LOAD;
      rnd_valid <= (WARMUP == 0);
      seed_err  <= 1'b0;
    end else begin
      seed_err <= seed_valid && !lane_ok;
      if (seed_valid) begin
        if (WARMUP == 0) begin
          state     <= ST_RUN;
          rnd_valid <= 1'b1;
        end else begin
          state     <= ST_WARMUP;
          cnt       <= WARM_LOAD;
          rnd_valid <= 1'b0;
        end
      end else if (state == ST_WARMUP) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state     <= ST_RUN;
          rnd_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_taus88_multi_core.sv
// Directed bench: a single-lane no-warm-up instance and a four-lane WARMUP=10 instance.
`timescale 1ns/1ps
module tb_taus88_multi_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_na, sv_a, sr_a, serr_a, rv_a, rr_a;
  logic [3:0]  sl_a;
  logic [95:0] sd_a;
  logic [31:0] rd_a;

  logic         rst_nb, sv_b, sr_b, serr_b, rv_b, rr_b;
  logic [3:0]   sl_b;
  logic [95:0]  sd_b;
  logic [127:0] rd_b;

  taus88_multi_core #(.LANES(1), .WARMUP(0)) dut_a (
    .clk(clk), .rst_n(rst_na), .seed_valid(sv_a), .seed_ready(sr_a), .seed_lane(sl_a),
    .seed_data(sd_a), .seed_err(serr_a), .rnd_valid(rv_a), .rnd_ready(rr_a), .rnd_data(rd_a));

  taus88_multi_core #(.LANES(4), .WARMUP(10)) dut_b (
    .clk(clk), .rst_n(rst_nb), .seed_valid(sv_b), .seed_ready(sr_b), .seed_lane(sl_b),
    .seed_data(sd_b), .seed_err(serr_b), .rnd_valid(rv_b), .rnd_ready(rr_b), .rnd_data(rd_b));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference Taus88, written directly from the C recurrence.
  function automatic logic [31:0] m_s1(input logic [31:0] s);
    logic [31:0] b;
    b = ((s << 13) ^ s) >> 19;
    return ((s & 32'hFFFFFFFE) << 12) ^ b;
  endfunction
  function automatic logic [31:0] m_s2(input logic [31:0] s);
    logic [31:0] b;
    b = ((s << 2) ^ s) >> 25;
    return ((s & 32'hFFFFFFF8) << 4) ^ b;
  endfunction
  function automatic logic [31:0] m_s3(input logic [31:0] s);
    logic [31:0] b;
    b = ((s << 3) ^ s) >> 11;
    return ((s & 32'hFFFFFFF0) << 17) ^ b;
  endfunction
  function automatic logic [95:0] m_fix(input logic [95:0] d);
    logic [31:0] a, b, c;
    a = d[31:0]; b = d[63:32]; c = d[95:64];
    if (a < 32'd2)  a = a + 32'd2;
    if (b < 32'd8)  b = b + 32'd8;
    if (c < 32'd16) c = c + 32'd16;
    return {c, b, a};
  endfunction

  logic [31:0] ma [3];
  logic [31:0] mb [4][3];

  task automatic a_step();
    ma[0] = m_s1(ma[0]); ma[1] = m_s2(ma[1]); ma[2] = m_s3(ma[2]);
  endtask

  task automatic b_model_reset();
    for (int k = 0; k < 4; k++) begin
      mb[k][0] = 32'd1634404289 + 32'(k);
      mb[k][1] = 32'd8 + 32'(k);
      mb[k][2] = 32'd16 + 32'(k);
    end
  endtask

  function automatic logic [127:0] b_out();
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[32*k +: 32] = mb[k][0] ^ mb[k][1] ^ mb[k][2];
    return r;
  endfunction

  // rr_b stays high, so every edge advances all lanes except a freshly loaded one.
  task automatic b_tick(input logic v, input logic [3:0] ln, input logic [95:0] d);
    logic [95:0] f;
    sv_b = v; sl_b = ln; sd_b = d;
    @(posedge clk); #1;
    sv_b = 1'b0;
    f = m_fix(d);
    for (int k = 0; k < 4; k++) begin
      if (v && (int'(ln) == k)) begin
        mb[k][0] = f[31:0]; mb[k][1] = f[63:32]; mb[k][2] = f[95:64];
      end else begin
        mb[k][0] = m_s1(mb[k][0]); mb[k][1] = m_s2(mb[k][1]); mb[k][2] = m_s3(mb[k][2]);
      end
    end
  endtask

  task automatic b_warm(input string name, input logic err_exp);
    for (int k = 0; k <= 10; k++) begin
      chk($sformatf("%s_valid_c%0d", name, k), rv_b, (k == 10));
      chk($sformatf("%s_data_c%0d", name, k), rd_b, b_out());
      chk($sformatf("%s_err_c%0d", name, k), serr_b, err_exp && (k == 0));
      if (k < 10) b_tick(1'b0, 4'd0, 96'd0);
    end
  endtask

  task automatic b_reset();
    rst_nb = 1'b0;
    b_model_reset();
    #1;
    chk("b_rst_valid", rv_b, 1'b0);
    chk("b_rst_data", rd_b, b_out());
    chk("b_rst_seed_ready", sr_b, 1'b1);
    @(posedge clk); #1;
    rst_nb = 1'b1;
  endtask

  typedef struct {
    logic        sv;
    logic [3:0]  lane;
    logic [95:0] sd;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
  } vec_t;

  vec_t tab [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d1;
    rst_na = 1'b0; sv_a = 1'b0; sl_a = 4'd0; sd_a = 96'd0; rr_a = 1'b0;
    rst_nb = 1'b0; sv_b = 1'b0; sl_b = 4'd0; sd_b = 96'd0; rr_b = 1'b1;

    d1 = m_s1(32'd1634404289) ^ m_s2(32'd8) ^ m_s3(32'd16);
    tab[0] = '{1'b0, 4'd0, 96'd0, 1'b1, 1'b1, 32'd1634404289 ^ 32'd8 ^ 32'd16};
    tab[1] = '{1'b1, 4'd0, {32'd3, 32'd2, 32'd1}, 1'b1, 1'b1, d1};
    tab[2] = '{1'b0, 4'd0, 96'd0, 1'b1, 1'b1, 32'd26};
    tab[3] = '{1'b0, 4'd0, 96'd0, 1'b1, 1'b1, 32'd2105472};
    tab[4] = '{1'b0, 4'd0, 96'd0, 1'b0, 1'b1, 32'd33565824};
    tab[5] = '{1'b0, 4'd0, 96'd0, 1'b0, 1'b1, 32'd33565824};

    // ---- Instance A: LANES=1, WARMUP=0 ----
    @(posedge clk); #1;
    rst_na = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sv_a = tab[i].sv; sl_a = tab[i].lane; sd_a = tab[i].sd; rr_a = tab[i].rdy;
      chk($sformatf("a_vec%0d_valid", i), rv_a, tab[i].ev);
      chk($sformatf("a_vec%0d_data", i), rd_a, tab[i].ed);
      @(posedge clk); #1;
      sv_a = 1'b0;
    end

    // Backpressure: word must hold, then resume without skip or repeat.
    ma[0] = 32'd33554560; ma[1] = 32'd2048; ma[2] = 32'd9216;
    rr_a = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("a_hold_c%0d", i), rd_a, 32'd33565824);
      @(posedge clk); #1;
    end
    rr_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("a_resume_c%0d", i), rd_a, ma[0] ^ ma[1] ^ ma[2]);
      @(posedge clk); #1;
      a_step();
    end

    // Mid-stream reset, then 1000 transfers against the model.
    #2 rst_na = 1'b0;
    #1 chk("a_midrst_data", rd_a, 32'd1634404289 ^ 32'd8 ^ 32'd16);
    @(posedge clk); #1;
    rst_na = 1'b1;
    ma[0] = 32'd1634404289; ma[1] = 32'd8; ma[2] = 32'd16;
    for (int i = 0; i < 1000; i++) begin
      chk($sformatf("a_seq_valid_%0d", i), rv_a, 1'b1);
      chk($sformatf("a_seq_data_%0d", i), rd_a, ma[0] ^ ma[1] ^ ma[2]);
      @(posedge clk); #1;
      a_step();
    end
    rr_a = 1'b0;

    // ---- Instance B: LANES=4, WARMUP=10 ----
    b_reset();
    b_warm("b_warm_rst", 1'b0);
    for (int i = 0; i < 3; i++) begin
      b_tick(1'b0, 4'd0, 96'd0);
      chk($sformatf("b_run_valid_%0d", i), rv_b, 1'b1);
      chk($sformatf("b_run_data_%0d", i), rd_b, b_out());
    end

    // Re-seed lane 2 during continuous transfer.
    b_tick(1'b1, 4'd2, {32'd3, 32'd2, 32'd1});
    chk("b_lane2_fixup", rd_b[95:64], 32'd26);
    b_warm("b_seed2", 1'b0);

    // Out-of-range lane: error pulse, no load, warm-up restart.
    b_tick(1'b1, 4'd7, {32'd5, 32'd6, 32'd7});
    b_warm("b_badlane", 1'b1);

    // Seed at cycle 5 of warm-up pushes valid to 10 cycles after the seed.
    b_reset();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("b_pre_seed_valid_%0d", i), rv_b, 1'b0);
      b_tick(1'b0, 4'd0, 96'd0);
    end
    b_tick(1'b1, 4'd1, {32'd300, 32'd200, 32'd100});
    b_warm("b_seed_c5", 1'b0);

    // Asynchronous reset mid-RUN.
    b_tick(1'b0, 4'd0, 96'd0);
    #2 rst_nb = 1'b0;
    b_model_reset();
    #1;
    chk("b_midrst_valid", rv_b, 1'b0);
    chk("b_midrst_data", rd_b, b_out());
    @(posedge clk); #1;
    rst_nb = 1'b1;
    b_warm("b_after_rst", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/taus88_multi_core.md
# taus88_multi_core

Parametrised successor to the single-lane Taus88 generator. Runs `LANES` independent Taus88 lanes in lockstep and presents their outputs as one wide word with a valid/ready stream handshake. Each lane's three components can be re-seeded at run time through a separate handshake, with automatic seed fix-up and a configurable warm-up discard. It sits between the seeding/control logic and any stochastic datapath that consumes several random words per cycle.

## Interface
Parameters:
- `LANES`, 4, number of independent Taus88 lanes (1..16)
- `WARMUP`, 10, state advances discarded after reset or any seed load (0 allowed)

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous and active-low
- `seed_valid`  in  1  seed request
- `seed_ready`  out  1  seed can be accepted
- `seed_lane`  in  4  target lane index
- `seed_data`  in  96  {s3, s2, s1}, 32 bits each
- `seed_err`  out  1  one-cycle pulse: accepted seed had `seed_lane >= LANES`
- `rnd_valid`  out  1  `rnd_data` is valid
- `rnd_ready`  in  1  consumer takes `rnd_data`
- `rnd_data`  out  32*LANES  lane k in bits [32k+31:32k]

## Operation
- Per lane, components s1/s2/s3 use the standard Taus88 recurrence: masks FFFFFFFE/FFFFFFF8/FFFFFFF0, shifts (13,19,12), (2,25,4), (3,11,17). All arithmetic is 32-bit and truncating.
- Lane output is s1^s2^s3 of the current registers, taken combinationally from the state flops.
- Default seeds for lane k: s1 = 1634404289+k, s2 = 8+k, s3 = 16+k.
- Seed fix-up is applied at load: if s1<2 then s1+=2; if s2<8 then s2+=8; if s3<16 then s3+=16. Each component is checked independently.
- FSM states:
  - WARMUP: counter > 0; all lanes advance every cycle; counter decrements; go to RUN when the counter reaches 0.
  - RUN: `rnd_valid`=1; all lanes advance only on `rnd_valid && rnd_ready`.
- Entry to WARMUP: on reset, or on any accepted seed, the counter loads `WARMUP`. With `WARMUP`=0, the FSM enters RUN directly, so the next cycle has `rnd_valid`=1.
- `seed_ready` is always 1. A seed is accepted when `seed_valid` is high.
- Accepted seed with a valid lane: on the next edge the target lane loads the fixed-up seed instead of advancing. Other lanes behave as their current state dictates.
- Accepted seed with `seed_lane >= LANES`: no lane is loaded, `seed_err` pulses the next cycle, and the warm-up restart still occurs.
- Seed accepted in RUN in the same cycle as a data transfer: the transfer completes and non-target lanes advance. The target lane loads. Next state is WARMUP, or RUN if `WARMUP`=0.
- Seed during WARMUP: the counter reloads to `WARMUP`.

## Timing
- Reset values: all lanes at default seeds, FSM in WARMUP with counter=`WARMUP` (or RUN if 0), `rnd_valid`=0, `seed_err`=0, `seed_ready`=1.
- Reset is asynchronous assert and synchronous-safe deassert. Reset mid-stream discards all state immediately.
- Latency:
  - first `rnd_valid` occurs `WARMUP` cycles after reset release or seed acceptance;
  - after a transfer, the next word is visible the following cycle, giving 1 word/cycle with `rnd_ready` held high.
- `rnd_data` is stable while `rnd_valid && !rnd_ready`, since no advance occurs.
- `rnd_valid` drops the cycle after a seed is accepted whenever `WARMUP`>0.

## Structure
- Package `taus88_pkg` holds:
  - masks, shift amounts, minimum seed values (2/8/16) and `S1_INIT/S2_INIT/S3_INIT`;
  - function `taus88_step` (one component step, parameterised by mask/shifts);
  - function `taus88_fixup`.
- Sub-module `taus88_lane` holds three 32-bit registers with inputs `adv`, `load` and `seed[95:0]` (already fixed up), an output for the XOR word, and a `LANE_ID` parameter for default seeds. The top level instantiates `LANES` of these plus the FSM, warm-up counter (`$clog2(WARMUP+1)` bits) and seed decode.

## Test plan
- Reset with `WARMUP`=0, `LANES`=1: `rnd_data` = 1634404289^8^16 with `rnd_valid`=1 at the first post-reset cycle. Successive words match a C Taus88 model for 1000 transfers.
- `WARMUP`=0, seed lane 0 with {3,2,1}: fixed-up state is (3,10,19), so `rnd_data`=26. After one transfer `rnd_data`=8192^128^2097152=2105472.
- Backpressure: hold `rnd_ready`=0 for 20 cycles in RUN → `rnd_data` is unchanged. Then release → the sequence resumes with no skipped or repeated word.
- `WARMUP`=10: after reset `rnd_valid` rises exactly at cycle 10. The first word equals the model's 11th state. A seed at cycle 5 delays `rnd_valid` to 10 cycles after the seed.
- `LANES`=4, seed lane 2 during continuous transfer → lane 2 restarts from its fix-up and the other lanes keep their sequences uninterrupted. `seed_lane`=7 → `seed_err` pulses once and no lane changes.
- Assert `rst_n` low mid-RUN → `rnd_valid`=0 immediately and lanes return to defaults; after release the sequence matches the first scenario.
